// File: rtl/zbus_ioseq_if.sv
// Signal bundle between the Z80/DMA I/O paths, the internal port decoder and
// the ZX-bus pin drivers. The sequencer takes the slave side.
interface zbus_ioseq_if;
    logic        z_req;
    logic        z_rnw;
    logic [15:0] z_addr;
    logic [7:0]  z_wdata;
    logic        d_req;
    logic        d_rnw;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata;
    logic        porthit;
    logic        iorqge1;
    logic        iorqge2;
    logic [7:0]  bus_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic        iorq1_n;
    logic        iorq2_n;
    logic        drive_ff;
    logic        z_ack;
    logic        d_ack;
    logic [7:0]  rdata;
    logic [1:0]  owner;
    logic        busy;

    modport slave (
        input  z_req, z_rnw, z_addr, z_wdata,
        input  d_req, d_rnw, d_addr, d_wdata,
        input  porthit, iorqge1, iorqge2, bus_rdata,
        output bus_addr, bus_wdata, bus_rd, bus_wr, iorq1_n, iorq2_n,
        output drive_ff, z_ack, d_ack, rdata, owner, busy
    );

    modport master (
        output z_req, z_rnw, z_addr, z_wdata,
        output d_req, d_rnw, d_addr, d_wdata,
        output porthit, iorqge1, iorqge2, bus_rdata,
        input  bus_addr, bus_wdata, bus_rd, bus_wr, iorq1_n, iorq2_n,
        input  drive_ff, z_ack, d_ack, rdata, owner, busy
    );
endinterface

// File: rtl/zbus_ioseq.sv
// ZX-bus I/O cycle sequencer: arbitrates Z80/DMA requests, tries the internal
// decoder, then runs the IORQ1/IORQ2 daisy-chain claim and holds the strobes.
module zbus_ioseq #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned STROBE = 6
) (
    input logic         fclk,
    input logic         rst,
    zbus_ioseq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DECODE, P1, P2, HOLD, DONE} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       rnw;
    logic       grant_dma;
    logic       last_dma;
    logic       pick_dma;

    // last_dma resets high so that simultaneous requests go to the Z80 first
    assign pick_dma = bus.d_req && (!bus.z_req || !last_dma);

    always_ff @(posedge fclk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rnw           <= 1'b1;
            grant_dma     <= 1'b0;
            last_dma      <= 1'b1;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_rd    <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.iorq1_n   <= 1'b1;
            bus.iorq2_n   <= 1'b1;
            bus.drive_ff  <= 1'b0;
            bus.z_ack     <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.rdata     <= 8'hFF;
            bus.owner     <= 2'd0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.z_req || bus.d_req) begin
                        grant_dma     <= pick_dma;
                        last_dma      <= pick_dma;
                        bus.bus_addr  <= pick_dma ? bus.d_addr : bus.z_addr;
                        bus.bus_wdata <= pick_dma ? bus.d_wdata : bus.z_wdata;
                        rnw           <= pick_dma ? bus.d_rnw : bus.z_rnw;
                        bus.busy      <= 1'b1;
                        state         <= DECODE;
                    end
                end

                DECODE: begin
                    if (bus.porthit) begin
                        bus.owner <= 2'd0;
                        bus.z_ack <= !grant_dma;
                        bus.d_ack <= grant_dma;
                        state     <= DONE;
                    end else begin
                        bus.iorq1_n <= 1'b0;
                        bus.bus_rd  <= rnw;
                        bus.bus_wr  <= !rnw;
                        cnt         <= 8'(SETTLE);
                        state       <= P1;
                    end
                end

                P1: begin
                    if (cnt == 8'd1) begin
                        if (bus.iorqge1) begin
                            bus.owner <= 2'd1;
                            cnt       <= 8'(STROBE);
                            state     <= HOLD;
                        end else begin
                            bus.iorq2_n <= 1'b0;
                            cnt         <= 8'(SETTLE);
                            state       <= P2;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                P2: begin
                    if (cnt == 8'd1) begin
                        bus.owner    <= bus.iorqge2 ? 2'd2 : 2'd3;
                        bus.drive_ff <= !bus.iorqge2 && rnw;
                        cnt          <= 8'(STROBE);
                        state        <= HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                HOLD: begin
                    if (cnt == 8'd1) begin
                        // only external claims and the free bus reach HOLD
                        if (rnw) begin
                            bus.rdata <= (bus.owner == 2'd3) ? 8'hFF : bus.bus_rdata;
                        end
                        bus.iorq1_n  <= 1'b1;
                        bus.iorq2_n  <= 1'b1;
                        bus.bus_rd   <= 1'b0;
                        bus.bus_wr   <= 1'b0;
                        bus.drive_ff <= 1'b0;
                        bus.z_ack    <= !grant_dma;
                        bus.d_ack    <= grant_dma;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                DONE: begin
                    bus.z_ack <= 1'b0;
                    bus.d_ack <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_zbus_ioseq.sv
// Bench for zbus_ioseq: a timeline model of each granted cycle, checked every
// cycle, plus directed scenarios with hand-computed cycle numbers.
module tb_zbus_ioseq;
    localparam int S = 2;
    localparam int T = 6;

    logic fclk = 1'b0;
    logic rst  = 1'b1;
    always #5 fclk = ~fclk;

    zbus_ioseq_if zif ();
    assign zif.porthit = (zif.bus_addr[7:0] == 8'hFE);

    zbus_ioseq #(.SETTLE(S), .STROBE(T)) dut (
        .fclk (fclk),
        .rst  (rst),
        .bus  (zif)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    bit model_valid = 1'b0;
    bit rand_en     = 1'b0;

    // requester side: one outstanding transaction per requester (0 Z80, 1 DMA)
    bit          pend [2];
    bit          tx_rnw [2];
    logic [15:0] tx_addr [2];
    logic [7:0]  tx_wdata [2];
    bit          tx_c1 [2];
    bit          tx_c2 [2];
    logic [7:0]  tx_rd [2];

    // model of the granted cycle as a timeline measured from its grant cycle
    bit          m_active = 1'b0;
    int          m_grant  = 0;
    int          m_len    = 0;
    bit          m_dma, m_rnw, m_hit, m_c1, m_c2;
    logic [1:0]  m_owner;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_bus_rd, m_new_rdata;
    bit          m_last_dma = 1'b1;
    logic [15:0] p_addr  = '0;
    logic [7:0]  p_wdata = '0;
    logic [7:0]  p_rdata = 8'hFF;
    logic [1:0]  p_owner = '0;

    int t0 = 0;
    int f_io1, l_io1, f_io2, l_io2, f_wr, l_wr, f_rd, f_ff, l_ff, ack_off, obs_acks;
    logic [7:0] obs_rdata;
    logic [1:0] obs_owner;
    bit ack_order [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic drive_reqs();
        zif.z_req   = pend[0];
        zif.z_rnw   = tx_rnw[0];
        zif.z_addr  = tx_addr[0];
        zif.z_wdata = tx_wdata[0];
        zif.d_req   = pend[1];
        zif.d_rnw   = tx_rnw[1];
        zif.d_addr  = tx_addr[1];
        zif.d_wdata = tx_wdata[1];
    endtask

    task automatic applyStimulus(input int r, input bit rnw, input logic [15:0] addr,
                                 input logic [7:0] wdata, input bit c1, input bit c2,
                                 input logic [7:0] rd);
        tx_rnw[r] = rnw;
        tx_addr[r] = addr;
        tx_wdata[r] = wdata;
        tx_c1[r] = c1;
        tx_c2[r] = c2;
        tx_rd[r] = rd;
        pend[r] = 1'b1;
        t0 = cyc;
        f_io1 = -1; l_io1 = -1; f_io2 = -1; l_io2 = -1;
        f_wr = -1; l_wr = -1; f_rd = -1; f_ff = -1; l_ff = -1;
        ack_off = -1; obs_acks = 0;
    endtask

    task automatic random_tx(input int r);
        logic [15:0] a;
        a = 16'($urandom);
        if ($urandom_range(0, 2) == 0) a[7:0] = 8'hFE;
        else if (a[7:0] == 8'hFE) a[7:0] = 8'hFD;
        tx_rnw[r] = 1'($urandom);
        tx_addr[r] = a;
        tx_wdata[r] = 8'($urandom);
        tx_c1[r] = ($urandom_range(0, 2) == 0);
        tx_c2[r] = 1'($urandom);
        tx_rd[r] = 8'($urandom);
        pend[r] = 1'b1;
    endtask

    // Compare the outputs registered by the last edge against the model timeline.
    task automatic next_cycle();
        int k;
        bit w1, w2, wff, at_ack, act1;
        @(negedge fclk);
        cyc++;
        if (model_valid) begin
            k = cyc - m_grant;
            act1 = m_active && (k >= 1);
            at_ack = m_active && (k == m_len);
            w1 = m_active && !m_hit && (k >= 2) && (k <= m_len - 1);
            w2 = w1 && !m_c1 && (k >= 2 + S);
            wff = w1 && (m_owner == 2'd3) && m_rnw && (k >= 2 + 2 * S);
            checkOutput("busy", 32'(zif.busy), 32'(act1));
            checkOutput("iorq1_n", 32'(zif.iorq1_n), 32'(!w1));
            checkOutput("iorq2_n", 32'(zif.iorq2_n), 32'(!w2));
            checkOutput("bus_rd", 32'(zif.bus_rd), 32'(w1 && m_rnw));
            checkOutput("bus_wr", 32'(zif.bus_wr), 32'(w1 && !m_rnw));
            checkOutput("drive_ff", 32'(zif.drive_ff), 32'(wff));
            checkOutput("z_ack", 32'(zif.z_ack), 32'(at_ack && !m_dma));
            checkOutput("d_ack", 32'(zif.d_ack), 32'(at_ack && m_dma));
            checkOutput("bus_addr", 32'(zif.bus_addr), 32'(act1 ? m_addr : p_addr));
            checkOutput("bus_wdata", 32'(zif.bus_wdata), 32'(act1 ? m_wdata : p_wdata));
            checkOutput("rdata", 32'(zif.rdata), 32'(at_ack ? m_new_rdata : p_rdata));
            if (!m_active || at_ack)
                checkOutput("owner", 32'(zif.owner), 32'(at_ack ? m_owner : p_owner));
        end
        if (zif.iorq1_n === 1'b0) begin if (f_io1 < 0) f_io1 = cyc - t0; l_io1 = cyc - t0; end
        if (zif.iorq2_n === 1'b0) begin if (f_io2 < 0) f_io2 = cyc - t0; l_io2 = cyc - t0; end
        if (zif.bus_wr === 1'b1) begin if (f_wr < 0) f_wr = cyc - t0; l_wr = cyc - t0; end
        if (zif.bus_rd === 1'b1) begin if (f_rd < 0) f_rd = cyc - t0; end
        if (zif.drive_ff === 1'b1) begin if (f_ff < 0) f_ff = cyc - t0; l_ff = cyc - t0; end
        if (zif.z_ack === 1'b1 || zif.d_ack === 1'b1) begin
            if (ack_off < 0) ack_off = cyc - t0;
            obs_acks++;
            ack_order.push_back(zif.d_ack === 1'b1);
            obs_rdata = zif.rdata;
            obs_owner = zif.owner;
        end
    endtask

    // Drive the inputs for this cycle, then advance the model past this edge.
    task automatic finish_cycle();
        int k;
        bit drop [2];
        k = cyc - m_grant;
        drop[0] = 1'b0;
        drop[1] = 1'b0;
        if (m_active && k == m_len) begin
            pend[m_dma] = 1'b0;
            drop[m_dma] = 1'b1;
        end
        if (rand_en) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && !drop[r] && $urandom_range(0, 3) == 0) random_tx(r);
            rst = ($urandom_range(0, 249) == 0);
        end
        drive_reqs();
        zif.iorqge1 = (m_active && k == 1 + S) ? m_c1 : 1'($urandom);
        zif.iorqge2 = (m_active && k == 1 + 2 * S) ? m_c2 : 1'($urandom);
        zif.bus_rdata = (m_active && k == m_len - 1) ? m_bus_rd : 8'($urandom);

        if (rst) begin
            m_active = 1'b0;
            m_last_dma = 1'b1;
            p_addr = '0;
            p_wdata = '0;
            p_rdata = 8'hFF;
            p_owner = 2'd0;
            model_valid = 1'b1;
        end else if (m_active && k == m_len) begin
            m_active = 1'b0;
            p_addr = m_addr;
            p_wdata = m_wdata;
            p_rdata = m_new_rdata;
            p_owner = m_owner;
        end else if (!m_active && (pend[0] || pend[1])) begin
            m_dma = pend[1] && (!pend[0] || !m_last_dma);
            m_last_dma = m_dma;
            m_active = 1'b1;
            m_grant = cyc;
            m_rnw = tx_rnw[m_dma];
            m_addr = tx_addr[m_dma];
            m_wdata = tx_wdata[m_dma];
            m_hit = (m_addr[7:0] == 8'hFE);
            m_c1 = tx_c1[m_dma];
            m_c2 = tx_c2[m_dma];
            m_bus_rd = tx_rd[m_dma];
            m_owner = m_hit ? 2'd0 : m_c1 ? 2'd1 : m_c2 ? 2'd2 : 2'd3;
            m_len = m_hit ? 2 : m_c1 ? 2 + S + T : 2 + 2 * S + T;
            m_new_rdata = (!m_rnw || m_hit) ? p_rdata : (m_owner == 2'd3) ? 8'hFF : m_bus_rd;
        end
    endtask

    task automatic wait_acks(input int n, input int budget);
        int c = 0;
        while (obs_acks < n && c < budget) begin
            next_cycle();
            finish_cycle();
            c++;
        end
        checkOutput("ack_count", obs_acks, n);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; tx_rnw[r] = 1'b1; tx_addr[r] = '0; tx_wdata[r] = '0;
            tx_c1[r] = 1'b0; tx_c2[r] = 1'b0; tx_rd[r] = '0;
        end
        drive_reqs();
        zif.iorqge1 = 1'b0;
        zif.iorqge2 = 1'b0;
        zif.bus_rdata = 8'h00;
        rst = 1'b1;
        applyStimulus(0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        pend[0] = 1'b0;

        next_cycle(); finish_cycle();
        next_cycle();
        checkOutput("reset_iorq1_n", 32'(zif.iorq1_n), 1);
        checkOutput("reset_iorq2_n", 32'(zif.iorq2_n), 1);
        checkOutput("reset_busy", 32'(zif.busy), 0);
        checkOutput("reset_drive_ff", 32'(zif.drive_ff), 0);
        checkOutput("reset_rdata", 32'(zif.rdata), 32'hFF);
        checkOutput("reset_owner", 32'(zif.owner), 0);
        checkOutput("reset_bus_addr", 32'(zif.bus_addr), 0);
        checkOutput("reset_acks", 32'({zif.z_ack, zif.d_ack}), 0);
        rst = 1'b0;
        finish_cycle();

        $display("[TB] Z80 read claimed by device 1");
        next_cycle(); applyStimulus(0, 1'b1, 16'hFFDF, 8'h00, 1'b1, 1'b0, 8'h5A); finish_cycle();
        wait_acks(1, 40);
        checkOutput("ext1_ack_cycle", ack_off, 10);
        checkOutput("ext1_iorq1_first", f_io1, 2);
        checkOutput("ext1_iorq1_last", l_io1, 9);
        checkOutput("ext1_iorq2_never", f_io2, -1);
        checkOutput("ext1_rdata", 32'(obs_rdata), 32'h5A);
        checkOutput("ext1_owner", 32'(obs_owner), 1);

        $display("[TB] Z80 read hitting the internal decoder");
        next_cycle(); applyStimulus(0, 1'b1, 16'h00FE, 8'h00, 1'b1, 1'b1, 8'h11); finish_cycle();
        wait_acks(1, 20);
        checkOutput("hit_ack_cycle", ack_off, 2);
        checkOutput("hit_owner", 32'(obs_owner), 0);
        checkOutput("hit_rdata_kept", 32'(obs_rdata), 32'h5A);
        checkOutput("hit_iorq1_never", f_io1, -1);
        checkOutput("hit_iorq2_never", f_io2, -1);

        $display("[TB] DMA write claimed by device 2");
        next_cycle(); applyStimulus(1, 1'b0, 16'h1234, 8'hC3, 1'b0, 1'b1, 8'h00); finish_cycle();
        wait_acks(1, 40);
        checkOutput("dma_ack_cycle", ack_off, 12);
        checkOutput("dma_iorq2_first", f_io2, 4);
        checkOutput("dma_iorq2_last", l_io2, 11);
        checkOutput("dma_wr_first", f_wr, 2);
        checkOutput("dma_wr_last", l_wr, 11);
        checkOutput("dma_rd_never", f_rd, -1);
        checkOutput("dma_owner", 32'(obs_owner), 2);

        $display("[TB] simultaneous requests");
        ack_order.delete();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            applyStimulus(0, 1'b1, 16'h00FE, 8'(i), 1'b0, 1'b0, 8'h00);
            applyStimulus(1, 1'b0, 16'h01FE, 8'(i + 8'h40), 1'b0, 1'b0, 8'h00);
            finish_cycle();
            wait_acks(2, 30);
        end
        checkOutput("arb_ack_total", ack_order.size(), 8);
        for (int i = 0; i < ack_order.size() && i < 8; i++)
            checkOutput($sformatf("arb_grant%0d", i), 32'(ack_order[i]), i % 2);

        $display("[TB] Z80 read of a free bus");
        next_cycle(); applyStimulus(0, 1'b1, 16'h7FFD, 8'h00, 1'b0, 1'b0, 8'h99); finish_cycle();
        wait_acks(1, 40);
        checkOutput("free_ack_cycle", ack_off, 12);
        checkOutput("free_ff_first", f_ff, 6);
        checkOutput("free_ff_last", l_ff, 11);
        checkOutput("free_rdata", 32'(obs_rdata), 32'hFF);
        checkOutput("free_owner", 32'(obs_owner), 3);

        $display("[TB] reset in the middle of an external read");
        next_cycle(); applyStimulus(0, 1'b1, 16'hBFFD, 8'h00, 1'b0, 1'b1, 8'h3C); finish_cycle();
        repeat (4) begin next_cycle(); finish_cycle(); end
        next_cycle(); rst = 1'b1; finish_cycle();
        next_cycle();
        checkOutput("rstmid_iorq1_n", 32'(zif.iorq1_n), 1);
        checkOutput("rstmid_iorq2_n", 32'(zif.iorq2_n), 1);
        checkOutput("rstmid_bus_rd", 32'(zif.bus_rd), 0);
        checkOutput("rstmid_busy", 32'(zif.busy), 0);
        rst = 1'b0;
        finish_cycle();
        wait_acks(1, 40);
        checkOutput("rstmid_ack_cycle", ack_off, 18);
        checkOutput("rstmid_rdata", 32'(obs_rdata), 32'h3C);
        checkOutput("rstmid_owner", 32'(obs_owner), 2);

        $display("[TB] randomized traffic");
        rand_en = 1'b1;
        repeat (2000) begin next_cycle(); finish_cycle(); end
        rand_en = 1'b0;
        next_cycle(); rst = 1'b0; finish_cycle();
        begin
            int c = 0;
            while ((pend[0] || pend[1] || m_active) && c < 200) begin
                next_cycle();
                finish_cycle();
                c++;
            end
        end
        checkOutput("drain_idle", 32'(pend[0] || pend[1] || m_active), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/zbus_ioseq.md
# zbus_ioseq

Sequencer and arbiter for external ZX-bus I/O cycles. It accepts I/O requests from the Z80 front-end and the DMA engine, grants one at a time, and checks the internal port decoder first. On a miss it runs the IORQ1/IORQGE1 → IORQ2/IORQGE2 daisy-chain claim sequence, then holds the strobes for a programmable length. It returns read data, or 0xFF with drive_ff when nobody claims the cycle. It sits between the CPU/DMA I/O paths and the ZX-bus pin drivers.

## Interface
- SETTLE, 2: cycles each IORQn strobe is low before its IORQGEn is sampled; legal 1..255
- STROBE, 6: cycles strobes are held after the claim is resolved; legal 1..255

- fclk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- z_req  in  1  Z80 I/O request, level, held until z_ack
- z_rnw  in  1  Z80 read(1)/write(0)
- z_addr  in  16  Z80 port address
- z_wdata  in  8  Z80 write data
- d_req, d_rnw, d_addr, d_wdata  in  1/1/16/8  same for DMA
- porthit  in  1  internal decoder hit for bus_addr (combinational from bus_addr)
- iorqge1, iorqge2  in  1  external claim lines, already fclk-synchronous
- bus_rdata  in  8  ZX-bus data in
- bus_addr  out  16  latched address of granted cycle
- bus_wdata  out  8  latched write data
- bus_rd, bus_wr  out  1  read/write strobes to ZX-bus
- iorq1_n, iorq2_n  out  1  daisy-chain IORQ strobes, active-low
- drive_ff  out  1  drive 0xFF onto free bus
- z_ack, d_ack  out  1  one-cycle completion pulse per requester
- rdata  out  8  read result, valid in the ack cycle and held until next ack
- owner  out  2  0 internal, 1 ext device 1, 2 ext device 2, 3 free bus; valid from ack
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, DECODE, P1, P2, HOLD, DONE.
- IDLE: if any request is pending, latch the granted request's addr, wdata and rnw, then go to DECODE.
  - Both pending: the requester not granted last wins, via a round-robin bit.
  - The rr bit resets to prefer Z80.
- DECODE (1 cycle): sample porthit.
  - Hit: owner=0, go to DONE. No external strobe is asserted.
  - Miss: go to P1.
- P1: iorq1_n=0; bus_rd=rnw, bus_wr=!rnw. Load counter=SETTLE. On the last P1 cycle, sample iorqge1:
  - iorqge1=1: owner=1, go to HOLD; iorq2_n stays 1.
  - iorqge1=0: go to P2.
- P2: iorq1_n=0, iorq2_n=0. After SETTLE cycles, sample iorqge2: owner=2 if high, else 3. Go to HOLD.
- HOLD: strobes unchanged for STROBE cycles. drive_ff=1 throughout HOLD iff owner=3 and rnw=1. On the last HOLD cycle, rdata ← bus_rdata (owner 1/2), 0xFF (owner 3), or unchanged (owner 0 or write).
- DONE (1 cycle): all strobes inactive (iorq*_n=1, bus_rd=bus_wr=drive_ff=0). The granted ack pulses. Go to IDLE.
- Requester drops req on the edge that samples ack high. IDLE never re-grants the same request.
- Free-bus write completes normally with owner=3 and no drive_ff.
- Strobe outputs are registered and glitch-free. iorq2_n is never low while iorq1_n is high.

## Timing
- Reset values: iorq1_n=1, iorq2_n=1, bus_rd=0, bus_wr=0, drive_ff=0, z_ack=d_ack=0, busy=0, rdata=0xFF, owner=0, bus_addr=0, bus_wdata=0.
- Let cycle 0 be the IDLE cycle in which a request is granted. Ack occurs at:
  - porthit: cycle 2
  - owner 1: cycle 2+SETTLE+STROBE (defaults: 10)
  - owner 2/3: cycle 2+2·SETTLE+STROBE (defaults: 12)
- Strobes go low at cycle 2. iorq2_n goes low at cycle 2+SETTLE.
- Back-to-back requests: the next grant happens in the IDLE cycle after DONE, so the minimum gap between acks is 3 cycles.
- Reset mid-cycle: the next edge forces IDLE and reset values, no ack is issued, and pending requests are re-arbitrated after rst falls.
- iorqge changes outside its sample cycle are ignored.
- Counter is 8-bit, loaded with SETTLE or STROBE on state entry, exit when it reaches 1.

## Test plan
- Z80 read 0x00FE, porthit=1 → z_ack at cycle 2, owner=0, iorq1_n/iorq2_n never low.
- Z80 read 0xFFDF, iorqge1=1, bus_rdata=0x5A, defaults → iorq1_n low cycles 2–9, iorq2_n high throughout, z_ack at cycle 10, rdata=0x5A, owner=1.
- DMA write 0x1234←0xC3, iorqge1=0, iorqge2=1 → iorq2_n low cycles 4–11, bus_wr high cycles 2–11, d_ack at cycle 12, owner=2.
- Z80 read, nobody claims → drive_ff high cycles 6–11, rdata=0xFF, owner=3, z_ack at cycle 12.
- z_req and d_req asserted in the same cycle, repeated 4 times → grants alternate Z80, DMA, Z80, DMA; each ack only to its requester.
- rst pulsed at cycle 5 of an external read → next cycle all strobes inactive, no ack, busy=0; request re-served in full after release.
